mem_req_sequencer: RTL

//  Upstream request sequencer for the 256x8 level-sensitive memory array.

---
 rtl/mem_seq_pkg.sv | 13 +
 rtl/mem_seq_addr_gen.sv | 32 +++
 rtl/mem_req_sequencer.sv | 113 +++++++++++
 3 files changed

// File: rtl/mem_seq_pkg.sv
// mem_seq_pkg: shared widths, FSM state and request record for mem_req_sequencer (MEM_SEQ_BURST_EN selects burst reads)
package mem_seq_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;
  localparam int LEN_W  = 4;
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_e;
  typedef struct packed {
    logic              write;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic [LEN_W-1:0]  len;
  } req_t;
endpackage

// File: rtl/mem_seq_addr_gen.sv
// mem_seq_addr_gen: loadable wrapping address counter with remaining-beat count and last flag
module mem_seq_addr_gen #(
  parameter int ADDR_W = mem_seq_pkg::ADDR_W,
  parameter int LEN_W  = mem_seq_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_i,
  input  logic              step_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [LEN_W-1:0]  len_i,
  output logic [ADDR_W-1:0] addr_o,
  output logic              last_o
);
  logic [ADDR_W-1:0] addr_q;
  logic [LEN_W-1:0]  rem_q;
  // load start address and extra beats on accept; advance one beat per step, wrapping naturally
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      addr_q <= '0;
      rem_q  <= '0;
    end else if (load_i) begin
      addr_q <= addr_i;
      rem_q  <= len_i;
    end else if (step_i) begin
      addr_q <= addr_q + 1'b1;
      rem_q  <= rem_q - 1'b1;
    end
  end
  assign addr_o = addr_q;
  assign last_o = (rem_q == '0);
endmodule

// File: rtl/mem_req_sequencer.sv
// mem_req_sequencer: valid/ready request sequencer driving a 256x8 array; define MEM_SEQ_BURST_EN for multi-beat reads
module mem_req_sequencer #(
  parameter int ADDR_W = mem_seq_pkg::ADDR_W,
  parameter int DATA_W = mem_seq_pkg::DATA_W,
  parameter int LEN_W  = mem_seq_pkg::LEN_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [LEN_W-1:0]  req_len,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_write,
  output logic              rsp_last,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_data_in,
  input  logic [DATA_W-1:0] mem_data_out,
  output logic              mem_read_write,
  output logic              mem_chip_en,
  output logic              busy
);
  import mem_seq_pkg::*;
  state_e            state_q;
  logic              write_q;
  logic [DATA_W-1:0] data_in_q;
  logic              rw_q;
  logic              ce_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_data_q;
  logic              rsp_write_q;
  logic              rsp_last_q;
  logic [ADDR_W-1:0] addr;
  logic              last;
  logic              accept;
  logic              next_beat;
  assign req_ready = (state_q == IDLE) && rst_n;
  assign accept    = req_valid && req_ready;
  assign next_beat = (state_q == RESP) && rsp_ready && !last;
`ifdef MEM_SEQ_BURST_EN
  mem_seq_addr_gen #(.ADDR_W(ADDR_W), .LEN_W(LEN_W)) u_addr_gen (
    .clk    (clk),
    .rst_n  (rst_n),
    .load_i (accept),
    .step_i (next_beat),
    .addr_i (req_addr),
    .len_i  (req_write ? '0 : req_len),
    .addr_o (addr),
    .last_o (last)
  );
`else
  logic [ADDR_W-1:0] addr_q;
  // single-beat build: hold the captured address; every beat is the last
  always_ff @(posedge clk) begin
    if (!rst_n) addr_q <= '0;
    else if (accept) addr_q <= req_addr;
  end
  assign addr = addr_q;
  assign last = 1'b1;
`endif
  // sequencer FSM with registered array strobes and response holding register
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      write_q     <= 1'b0;
      data_in_q   <= '0;
      rw_q        <= 1'b0;
      ce_q        <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_write_q <= 1'b0;
      rsp_last_q  <= 1'b0;
    end else begin
      case (state_q)
        IDLE: if (accept) begin
          state_q   <= ACCESS;
          write_q   <= req_write;
          data_in_q <= req_write ? req_wdata : '0;
          rw_q      <= req_write;
          ce_q      <= 1'b1;
        end
        ACCESS: begin
          state_q     <= RESP;
          ce_q        <= 1'b0;
          rw_q        <= 1'b0;
          rsp_valid_q <= 1'b1;
          rsp_data_q  <= write_q ? '0 : mem_data_out;
          rsp_write_q <= write_q;
          rsp_last_q  <= last;
        end
        RESP: if (rsp_ready) begin
          rsp_valid_q <= 1'b0;
          state_q     <= last ? IDLE : ACCESS;
          ce_q        <= !last;
        end
        default: state_q <= IDLE;
      endcase
    end
  end
  assign mem_address    = addr;
  assign mem_data_in    = data_in_q;
  assign mem_read_write = rw_q;
  assign mem_chip_en    = ce_q;
  assign rsp_valid      = rsp_valid_q;
  assign rsp_data       = rsp_data_q;
  assign rsp_write      = rsp_write_q;
  assign rsp_last       = rsp_last_q;
  assign busy           = (state_q != IDLE);
endmodule
